// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the alu_mdu execute unit.
//   alu_op_e    - 4-bit opcode presented on alu_mdu.op
//   alu_state_e - sequencing state of the execute unit
//   LINK_OFFSET - return-address offset added by LINK
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0001,
    OP_SUBU  = 4'b0010,
    OP_LUI   = 4'b0011,
    OP_OR    = 4'b0100,
    OP_PASS  = 4'b0101,
    OP_AND   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_LINK  = 4'b1001,
    OP_MULTU = 4'b1010,
    OP_DIVU  = 4'b1011,
    OP_MFHI  = 4'b1100,
    OP_MFLO  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } alu_state_e;

  localparam int unsigned LINK_OFFSET = 4;

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: WIDTH-step unsigned multiply / restoring divide datapath.
//   clk, rst        - clock, asynchronous active-high reset
//   start           - load operands and counter (counter := WIDTH)
//   is_div          - 1: divide op_a by op_b, 0: multiply op_a by op_b
//   op_a, op_b      - operands (multiplier/dividend, multiplicand/divisor)
//   done            - high during the final step; res_hi/res_lo then hold
//                     the finished HI/LO values (remainder/quotient for div)
//   res_hi, res_lo  - partial result after the step taken this cycle
module alu_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic             mode_div;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] part_hi;
  logic [WIDTH-1:0] part_lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  // Multiply: {part_hi, part_lo} starts as {0, multiplier}; each step adds
  // the multiplicand into the upper half when the current LSB is set, then
  // shifts the whole register (carry included) right by one.
  // Divide: part_lo holds the dividend shifting out MSB-first while quotient
  // bits shift in; part_hi holds the running remainder.
  always_comb begin
    mul_sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {part_hi, part_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift - {1'b0, opnd};
    if (mode_div) begin
      res_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      res_lo = {part_lo[WIDTH-2:0], div_ge};
    end else begin
      res_hi = mul_sum[WIDTH:1];
      res_lo = {mul_sum[0], part_lo[WIDTH-1:1]};
    end
  end

  assign done = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_div <= 1'b0;
      opnd     <= '0;
      part_hi  <= '0;
      part_lo  <= '0;
      cnt      <= '0;
    end else if (start) begin
      mode_div <= is_div;
      opnd     <= op_b;
      part_hi  <= '0;
      part_lo  <= op_a;
      cnt      <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      part_hi  <= res_hi;
      part_lo  <= res_lo;
      cnt      <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered EX-stage execute unit with single-cycle ALU ops and an
// iterative unsigned multiply/divide writing architectural HI/LO.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid / in_ready  - op handshake; accepted when both high at an edge
//   op, a, b             - opcode (alu_pkg::alu_op_e) and operands
//   result, zero, jr_sign- registered results, valid while out_valid is high
//   out_valid            - one-cycle completion pulse
//   busy                 - a multiply or divide is iterating
//   hi, lo               - architectural HI/LO registers
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             jr_sign,
  output logic             out_valid,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_state_e       state, state_next;
  logic             accept;
  logic             core_start, core_is_div, core_done;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] result_next, hi_next, lo_next;
  logic             zero_next, jr_next, ov_next;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  alu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (core_start),
    .is_div (core_is_div),
    .op_a   (a),
    .op_b   (b),
    .done   (core_done),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  // Single-cycle result selection.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUBU: alu_res = a - b;
      OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_OR:   alu_res = a | b;
      OP_PASS: alu_res = a;
      OP_AND:  alu_res = a & b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LINK: alu_res = b + WIDTH'(LINK_OFFSET);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next  = state;
    result_next = result;
    zero_next   = zero;
    jr_next     = jr_sign;
    ov_next     = 1'b0;
    hi_next     = hi;
    lo_next     = lo;
    core_start  = 1'b0;
    core_is_div = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op == OP_MULTU) begin
            core_start = 1'b1;
            state_next = MUL;
          end else if (op == OP_DIVU && b != '0) begin
            core_start  = 1'b1;
            core_is_div = 1'b1;
            state_next  = DIV;
          end else if (op == OP_DIVU) begin
            // Divide by zero completes immediately with fixed HI/LO values.
            hi_next     = a;
            lo_next     = '1;
            result_next = '1;
            jr_next     = 1'b0;
            ov_next     = 1'b1;
          end else begin
            result_next = alu_res;
            jr_next     = (op == OP_PASS);
            ov_next     = 1'b1;
            if (op == OP_SUBU) zero_next = (a == b);
          end
        end
      end
      MUL, DIV: begin
        if (core_done) begin
          hi_next     = core_hi;
          lo_next     = core_lo;
          result_next = core_lo;
          jr_next     = 1'b0;
          ov_next     = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      zero      <= 1'b0;
      jr_sign   <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state     <= state_next;
      result    <= result_next;
      zero      <= zero_next;
      jr_sign   <= jr_next;
      out_valid <= ov_next;
      hi        <= hi_next;
      lo        <= lo_next;
    end
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Registered, parametrised execute unit for the pipelined MIPS-subset CPU. It covers the existing single-cycle op set (add, subu with zero flag, lui, or, pass-A for jr, link) and adds and, slt, and an iterative unsigned multiply/divide unit with HI/LO registers. It sits in the EX stage behind a valid/ready handshake. The hazard unit stalls the pipe while `in_ready` is low.

## Interface
- `WIDTH`, 32: datapath width. Must be even and ≥ 8.
- `CNT_W`, $clog2(WIDTH+1): width of the iteration counter.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: an op is presented this cycle.
- `in_ready` output 1: unit can accept. The op is accepted when `in_valid && in_ready` at a rising edge.
- `op` input 4: opcode (`alu_pkg::alu_op_e`).
- `a` input WIDTH: operand A (rs).
- `b` input WIDTH: operand B (rt, imm or PC).
- `result` output WIDTH: registered result.
- `zero` output 1: registered; set when the subu result == 0.
- `jr_sign` output 1: registered; high with the result of a PASS op.
- `out_valid` output 1: one-cycle pulse; `result`, `zero` and `jr_sign` are valid.
- `busy` output 1: a multiply or divide is iterating.
- `hi`, `lo` output WIDTH: architectural HI/LO registers.

## Operation
Opcodes:
- 0001 ADD: a+b, wraps mod 2^WIDTH.
- 0010 SUBU: a−b; `zero` = (a−b == 0).
- 0011 LUI: {b[WIDTH/2-1:0], WIDTH/2 zeros}.
- 0100 OR: a|b.
- 0101 PASS: a; `jr_sign`=1.
- 0110 AND: a&b.
- 0111 SLT: signed a<b, giving 1 or 0.
- 1001 LINK: b+4.
- 1010 MULTU: {hi,lo} = a*b, unsigned.
- 1011 DIVU: lo = a/b, hi = a%b.
- 1100 MFHI: hi.
- 1101 MFLO: lo.
- Any other opcode: result 0, `out_valid` still pulses.

Per-output rules:
- `zero` is updated only by SUBU and holds otherwise.
- `jr_sign` is 1 only on a PASS completion and 0 on every other completion.

State machine (`IDLE`, `MUL`, `DIV`):
- IDLE: `in_ready`=1. A single-cycle op registers its result and stays in IDLE. MULTU goes to MUL and DIVU goes to DIV, with operands latched and the counter loaded with WIDTH.
- MUL: one shift-add step per cycle, least-significant multiplier bit first. The counter decrements each cycle. On the step where the counter is 1, HI/LO are written and the state goes to IDLE.
- DIV: one restoring shift-subtract step per cycle, using the same counter rule. On completion the quotient goes to LO and the remainder to HI.
- DIVU with b == 0: does not enter DIV. HI=a and LO=all ones are written at the accept edge, and `out_valid` pulses next cycle (1-cycle latency).
- MULTU/DIVU completion pulses `out_valid` with `result` = LO.

Boundary conditions:
- While `busy`: `in_ready`=0 and `in_valid` is ignored. No queueing.
- MFHI/MFLO accepted the same cycle a MULTU/DIVU completes is impossible, because `in_ready` is low until HI/LO are written.
- `rst` mid-iteration: aborts the operation. State→IDLE, HI/LO unchanged from the reset value (0). Nothing is partially written.

## Timing
- Reset values: `result`=0, `zero`=0, `jr_sign`=0, `out_valid`=0, `busy`=0, `in_ready`=1, `hi`=0, `lo`=0, state IDLE, counter 0.
- Single-cycle ops accepted at edge T:
  - `out_valid`=1 during cycle T+1.
  - Back-to-back issue every cycle is allowed.
- MULTU/DIVU (b≠0) accepted at edge T:
  - `busy`=1, `in_ready`=0 for cycles T+1 … T+WIDTH.
  - HI/LO are written at edge T+WIDTH.
  - `out_valid`=1, `busy`=0, `in_ready`=1 during cycle T+WIDTH+1.
  - Latency WIDTH+1. A new op may be accepted at edge T+WIDTH+1.
- `out_valid` is never high for two consecutive cycles from the same op.

## Structure
- `alu_pkg`: `alu_op_e` enum (4-bit encodings above), `alu_state_e` {IDLE, MUL, DIV}, `LINK_OFFSET`=4.
- Sub-module `alu_iter_core`: the WIDTH-step multiply/divide datapath (operand and partial registers, counter, done strobe).
- Top level: decode, the single-cycle ops, the FSM, HI/LO and the output registers.

## Test plan
- Reset, then ADD a=0xFFFFFFFF, b=1 → next cycle `out_valid`=1, `result`=0, `zero` unchanged (0).
- SUBU a=b=0x1234 → `result`=0, `zero`=1. Then LUI b=0x0000ABCD → `result`=0xABCD0000, `zero` still 1. Then PASS a=0x400 → `jr_sign`=1. Then LINK b=0x3000 → `result`=0x3004, `jr_sign`=0.
- MULTU a=0xFFFFFFFF, b=2 at edge T → `in_ready` low for 32 cycles, `out_valid` in cycle T+33, hi=1, lo=0xFFFFFFFE. MFHI → 1.
- DIVU a=100, b=7 → lo=14, hi=2 after 33 cycles. DIVU a=5, b=0 → `out_valid` next cycle, hi=5, lo=0xFFFFFFFF.
- `in_valid` held with ADD during a DIVU → no extra `out_valid` until completion. ADD accepted at the first ready edge.
- `rst` asserted 10 cycles into a MULTU → immediate IDLE, hi=lo=0, `busy`=0, no `out_valid`.
- WIDTH=16 instance: MULTU 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001, latency 17.
